masked_nibble_perm_pipe: RTL and testbench

//  Share-wise linear/affine nibble layer for threshold-implemented (TI) SPN

---
 rtl/masked_nibble_perm_pipe.sv | 138 +++++++++++++
 tb/tb_masked_nibble_perm_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/masked_nibble_perm_pipe.sv
// -----------------------------------------------------------------------------
// masked_nibble_perm_pipe
//
// Share-wise linear/affine nibble layer for threshold-implemented SPN ciphers.
// Every 4-bit nibble of every share goes through a mode-selected bit
// permutation; in the affine mode the round constant is XORed into share 0
// only, so the unmasked value receives it exactly once. Shares are never
// mixed. The result enters an elastic valid/ready pipeline of PIPE stages.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   block accepts a beat this cycle
//   in_mode    transform select, sampled with the beat
//   in_data    SHARES shares of 4*NIBBLES bits, share s in slice s
//   out_valid  output beat valid
//   out_ready  downstream accepts
//   out_data   transformed shares, same packing as in_data
//   busy       at least one stage holds a beat
// -----------------------------------------------------------------------------
module masked_nibble_perm_pipe #(
  parameter int          NIBBLES = 16,
  parameter int          SHARES  = 3,
  parameter int          PIPE    = 1,
  parameter logic [63:0] RC      = 64'h0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  in_mode,
  input  logic [4*NIBBLES*SHARES-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [4*NIBBLES*SHARES-1:0] out_data,
  output logic                        busy
);

  localparam int SW = 4 * NIBBLES;  // bits per share
  localparam int DW = SW * SHARES;  // bits per beat

  // Only the low SW bits of the constant are meaningful.
  localparam logic [SW-1:0] RC_S0 = SW'(RC);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_REV    = 2'b01,
    MODE_REV_RC = 2'b10,
    MODE_ROTL   = 2'b11
  } mode_e;

  function automatic logic [3:0] perm(input mode_e m, input logic [3:0] b);
    case (m)
      MODE_REV, MODE_REV_RC: perm = {b[0], b[1], b[2], b[3]};
      MODE_ROTL:             perm = {b[2:0], b[3]};
      default:               perm = b;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Transform: purely combinational ahead of stage 0; the mode is consumed
  // here and is not carried down the pipeline.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] xf_data;
  mode_e         mode;

  assign mode = mode_e'(in_mode);

  always_comb begin
    // NOTE: assign a default before any conditional update so no path leaves
    // the variable unwritten; otherwise a latch is inferred.
    xf_data = '0;
    for (int s = 0; s < SHARES; s++) begin
      for (int n = 0; n < NIBBLES; n++) begin
        xf_data[s*SW + n*4 +: 4] = perm(mode, in_data[s*SW + n*4 +: 4]);
      end
    end
    // Affine part touches share 0 only, keeping the sharing uniform.
    if (mode == MODE_REV_RC) begin
      xf_data[SW-1:0] = xf_data[SW-1:0] ^ RC_S0;
    end
  end

  // ---------------------------------------------------------------------------
  // Elastic pipeline. A stage can load when it is empty or when the stage
  // after it can load too, so a full chain still moves one beat per cycle.
  // ---------------------------------------------------------------------------
  logic [PIPE-1:0] vld;
  logic [DW-1:0]   data     [PIPE];
  logic [PIPE-1:0] ready;
  logic [PIPE-1:0] src_vld;
  logic [DW-1:0]   src_data [PIPE];

  always_comb begin
    logic nxt;
    nxt   = out_ready;
    ready = '0;
    for (int k = PIPE - 1; k >= 0; k--) begin
      nxt      = !vld[k] || nxt;
      ready[k] = nxt;
    end
  end

  always_comb begin
    src_vld[0]  = in_valid;
    src_data[0] = xf_data;
    for (int k = 1; k < PIPE; k++) begin
      src_vld[k]  = vld[k-1];
      src_data[k] = data[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its predecessor's pre-edge value, independent of order.
      vld <= '0;
      for (int k = 0; k < PIPE; k++) data[k] <= '0;
    end else begin
      for (int k = 0; k < PIPE; k++) begin
        if (ready[k]) begin
          vld[k] <= src_vld[k];
          // Data only moves with a beat; idle input never reaches a stage.
          if (src_vld[k]) data[k] <= src_data[k];
        end
      end
    end
  end

  // Stages are cleared by the reset edge itself, so accepting is harmless to
  // advertise while rst is high; the reset branch discards any offered beat.
  assign in_ready  = rst || ready[0];
  assign out_valid = vld[PIPE-1];
  assign out_data  = data[PIPE-1];
  assign busy      = |vld;

endmodule

// File: tb/tb_masked_nibble_perm_pipe.sv
// -----------------------------------------------------------------------------
// Bench for masked_nibble_perm_pipe.
// dut1: NIBBLES=1, SHARES=3, PIPE=1, RC=4'h6 -- table-driven nibble vectors.
// dut : NIBBLES=2, SHARES=3, PIPE=3, RC=8'hA5 -- directed sequences and a
//       random stream checked by a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_masked_nibble_perm_pipe;

  localparam int          NIB  = 2;
  localparam int          SHR  = 3;
  localparam int          PIPE = 3;
  localparam int          SW   = 4 * NIB;
  localparam int          W    = SW * SHR;
  localparam logic [63:0] RC_M = 64'hA5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main DUT
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]   in_mode;
  logic [W-1:0] in_data, out_data;

  // table DUT
  logic        v1, r1, ov1, or1, b1;
  logic [1:0]  m1;
  logic [11:0] d1, od1;

  masked_nibble_perm_pipe #(.NIBBLES(NIB), .SHARES(SHR), .PIPE(PIPE), .RC(RC_M)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy));

  masked_nibble_perm_pipe #(.NIBBLES(1), .SHARES(3), .PIPE(1), .RC(64'h6)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
    .in_mode(m1), .in_data(d1), .out_valid(ov1),
    .out_ready(or1), .out_data(od1), .busy(b1));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: nibble-wise arithmetic, beats tracked in an ordered queue.
  // ---------------------------------------------------------------------------
  function automatic int nib_ref(input int m, input int v);
    int r;
    r = 0;
    case (m)
      1, 2: for (int b = 0; b < 4; b++) if ((v >> b) & 1) r = r | (1 << (3 - b));
      3:    r = ((v << 1) | (v >> 3)) & 15;
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] ref_xform(input logic [1:0] m, input logic [W-1:0] d);
    logic [W-1:0] o;
    int v, r;
    o = '0;
    for (int s = 0; s < SHR; s++) begin
      for (int n = 0; n < NIB; n++) begin
        v = int'(d[s*SW + n*4 +: 4]);
        r = nib_ref(int'(m), v);
        if (m == 2'b10 && s == 0) r = r ^ int'((RC_M >> (4 * n)) & 64'hF);
        o[s*SW + n*4 +: 4] = 4'(r);
      end
    end
    return o;
  endfunction

  logic [W-1:0] q[$];
  int           emit_log[$];
  int           cyc = 0;
  int           acc_cnt = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [W-1:0] last_out = '0;

  // One clock of stimulus on the main DUT, called at a falling edge.
  task automatic step(input logic v, input logic [1:0] m, input logic [W-1:0] d, input logic ordy);
    in_valid = v; in_mode = m; in_data = d; out_ready = ordy;
    #1;
    check("in_ready", in_ready, ordy || (q.size() < PIPE));
    check("busy", busy, q.size() != 0);
    if (prev_stall) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, prev_data);
    end
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        check("out_data", out_data, q.pop_front());
        emit_log.push_back(cyc);
        last_out = out_data;
      end
    end
    if (v && in_ready) begin
      q.push_back(ref_xform(m, d));
      acc_cnt++;
    end
    prev_stall = out_valid && !ordy;
    prev_data  = out_data;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      step(1'b0, 2'b00, '0, 1'b1);
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] din;   // {share2, share1, share0}
    logic [11:0] dout;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int c0, iter;
    logic [W-1:0] rd;

    tbl[0] = '{mode: 2'b01, din: 12'hE31, dout: 12'h7C8};
    tbl[1] = '{mode: 2'b11, din: 12'h999, dout: 12'h333};
    tbl[2] = '{mode: 2'b00, din: 12'h999, dout: 12'h999};
    tbl[3] = '{mode: 2'b10, din: 12'h000, dout: 12'h006};
    tbl[4] = '{mode: 2'b10, din: 12'h124, dout: 12'h844};
    tbl[5] = '{mode: 2'b11, din: 12'h8F0, dout: 12'h1F0};

    rst = 1'b1;
    in_valid = 1'b0; in_mode = '0; in_data = '0; out_ready = 1'b1;
    v1 = 1'b0; m1 = '0; d1 = '0; or1 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("in_ready_in_reset", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Table vectors on the single-nibble, single-stage instance.
    for (int i = 0; i < 6; i++) begin
      v1 = 1'b1; m1 = tbl[i].mode; d1 = tbl[i].din;
      @(negedge clk);
      v1 = 1'b0;
      #1;
      check($sformatf("tbl%0d_valid", i), ov1, 1'b1);
      check($sformatf("tbl%0d_data", i), od1, tbl[i].dout);
      if (i == 0) check("tbl0_unmasked", od1[11:8] ^ od1[7:4] ^ od1[3:0], 4'h3);
      @(negedge clk);
    end

    // Affine constant reaches share 0 only.
    step(1'b1, 2'b10, {8'h12, 8'h12, 8'h00}, 1'b1);
    drain();
    check("rc_shares", last_out, 24'h8484A5);
    check("rc_unmasked", last_out[23:16] ^ last_out[15:8] ^ last_out[7:0], 8'hA5);

    // Back-to-back beats: latency PIPE, then one beat per cycle.
    emit_log.delete();
    c0 = cyc;
    for (int i = 0; i < 8; i++) step(1'b1, 2'(i), W'($urandom()), 1'b1);
    drain();
    check("b2b_count", emit_log.size(), 8);
    if (emit_log.size() == 8) begin
      check("b2b_first", emit_log[0] - c0, PIPE);
      check("b2b_last", emit_log[7] - c0, PIPE + 7);
    end

    // Downstream stall with a running stream, then release.
    for (int i = 0; i < 2; i++) step(1'b1, 2'($urandom_range(0, 3)), W'($urandom()), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 2'($urandom_range(0, 3)), W'($urandom()), 1'b0);
    #1;
    check("stall_in_ready_low", in_ready, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    @(negedge clk);
    drain();

    // Reset with two beats in flight.
    step(1'b1, 2'b01, W'($urandom()), 1'b0);
    step(1'b1, 2'b11, W'($urandom()), 1'b0);
    rst = 1'b1; in_valid = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, '0);
    check("midrst_busy", busy, 1'b0);
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    step(1'b1, 2'b11, 24'h9C_3A_5F, 1'b1);
    drain();

    // Random stream with random stalls.
    acc_cnt = 0;
    iter = 0;
    while (acc_cnt < 1000 && iter < 10000) begin
      rd = W'($urandom());
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rd,
           1'($urandom_range(0, 3) != 0));
      iter++;
    end
    check("rand_accepted", acc_cnt, 1000);
    drain();
    #1;
    check("final_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
